core_reset_seq: RTL and testbench

CORE_RESET_SEQ -- requirements
Module: core_reset_seq

---
 rtl/core_reset_seq_if.sv | 24 ++
 rtl/core_reset_seq.sv | 151 +++++++++++++++
 tb/tb_core_reset_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_reset_seq_if.sv
// core_reset_seq_if -- control/status bundle of the core reset sequencer.
// The slave modport is the sequencer's view; the master modport is the
// view of whatever drives the requests (OSD, PLL wrapper, testbench).
interface core_reset_seq_if;
    logic       locked;
    logic       sw_reset;
    logic       img_mounted;
    logic       mount_reset_en;
    logic [1:0] cpu_sel;
    logic [3:0] core_nreset;
    logic [3:0] core_en;
    logic [1:0] active_cpu;
    logic       busy;

    modport master (
        output locked, sw_reset, img_mounted, mount_reset_en, cpu_sel,
        input  core_nreset, core_en, active_cpu, busy
    );

    modport slave (
        input  locked, sw_reset, img_mounted, mount_reset_en, cpu_sel,
        output core_nreset, core_en, active_cpu, busy
    );
endinterface

// File: rtl/core_reset_seq.sv
// core_reset_seq -- brings one of four CPU cores out of reset after PLL lock
// and on every core switch: all clocks gated for SETTLE_CYCLES, then the
// selected core clocked but held in reset for HOLD_CYCLES, then released.
// Optional feature: define CORE_RESET_SEQ_MOUNT_RESET_EN to let an image
// mount (img_mounted with mount_reset_en) act as a one-cycle sw_reset.
module core_reset_seq #(
    parameter int unsigned HOLD_CYCLES   = 1024,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input logic              clk_sys,
    input logic              reset,
    core_reset_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_HOLD,
        ST_RUN
    } state_e;

    localparam logic [15:0] HOLD_LOAD   = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_dec;
    logic [1:0]  act_q, act_d;
    logic [1:0]  sync_q, sync_d;
    logic [3:0]  core_en_q, core_en_d;
    logic [3:0]  core_nreset_q, core_nreset_d;
    logic [1:0]  active_cpu_q, active_cpu_d;
    logic        busy_q, busy_d;
    logic        lock_s;
    logic        rst_req;
    logic [3:0]  sel_onehot;

    assign lock_s     = sync_q[1];
    assign sel_onehot = 4'b0001 << act_q;

`ifdef CORE_RESET_SEQ_MOUNT_RESET_EN
    assign rst_req = bus.sw_reset | (bus.img_mounted & bus.mount_reset_en);
`else
    assign rst_req = bus.sw_reset;
`endif

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_comb begin
        sync_d = {sync_q[0], bus.locked};
    end

    // Next state, relatched core and down-counter; lock loss beats a core
    // switch, which beats a reset request.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        cnt_dec = (cnt_q == 16'd0) ? 16'd0 : cnt_q - 16'd1;

        if (state_q == ST_WAIT_LOCK) begin
            cnt_d = 16'd0;
            if (lock_s) begin
                state_d = ST_SETTLE;
                act_d   = bus.cpu_sel;
                cnt_d   = SETTLE_LOAD;
            end
        end else if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            act_d   = 2'd0;
            cnt_d   = 16'd0;
        end else if (bus.cpu_sel != act_q) begin
            state_d = ST_SETTLE;
            act_d   = bus.cpu_sel;
            cnt_d   = SETTLE_LOAD;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_q == 16'd0) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                ST_HOLD: begin
                    if (rst_req) begin
                        cnt_d = HOLD_LOAD;
                    end else if (cnt_q == 16'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                ST_RUN: begin
                    if (rst_req) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                end
            endcase
        end
    end

    // Output values decoded from the current state; registered one edge later.
    always_comb begin
        core_en_d     = 4'b0000;
        core_nreset_d = 4'b0000;
        busy_d        = (state_q != ST_RUN);
        active_cpu_d  = act_q;
        if (state_q == ST_HOLD || state_q == ST_RUN) begin
            core_en_d = sel_onehot;
        end
        if (state_q == ST_RUN) begin
            core_nreset_d = sel_onehot;
        end
    end

    // State, counter, synchroniser and output registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q       <= ST_WAIT_LOCK;
            cnt_q         <= 16'd0;
            act_q         <= 2'd0;
            sync_q        <= 2'b00;
            core_en_q     <= 4'b0000;
            core_nreset_q <= 4'b0000;
            active_cpu_q  <= 2'd0;
            busy_q        <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            act_q         <= act_d;
            sync_q        <= sync_d;
            core_en_q     <= core_en_d;
            core_nreset_q <= core_nreset_d;
            active_cpu_q  <= active_cpu_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.core_en     = core_en_q;
    assign bus.core_nreset = core_nreset_q;
    assign bus.active_cpu  = active_cpu_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_core_reset_seq.sv
// tb_core_reset_seq -- directed-plus-random bench for core_reset_seq with
// HOLD_CYCLES=8, SETTLE_CYCLES=4. Expected outputs come from a phase model:
// each scenario is a list of (length, phase, core) segments whose lengths
// are derived arithmetically from the sequencing rules, and each phase maps
// to fixed output values. Honours CORE_RESET_SEQ_MOUNT_RESET_EN if defined.
module tb_core_reset_seq;

    localparam int H = 8;
    localparam int S = 4;

    typedef enum {K_WAIT, K_SETTLE, K_HOLD, K_RUN} kind_e;

    logic clk_sys = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [1:0] cur;

    core_reset_seq_if bus ();

    core_reset_seq #(.HOLD_CYCLES(H), .SETTLE_CYCLES(S)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Compare all four outputs against the values a phase dictates.
    task automatic check_out(input string tag, input kind_e k, input logic [1:0] a);
        logic [3:0] onehot;
        logic [3:0] en_x;
        logic [3:0] nr_x;
        logic       busy_x;
        logic [1:0] act_x;
        onehot = 4'b0001 << a;
        case (k)
            K_WAIT:   begin en_x = 4'b0000; nr_x = 4'b0000; busy_x = 1'b1; act_x = 2'd0; end
            K_SETTLE: begin en_x = 4'b0000; nr_x = 4'b0000; busy_x = 1'b1; act_x = a;    end
            K_HOLD:   begin en_x = onehot;  nr_x = 4'b0000; busy_x = 1'b1; act_x = a;    end
            default:  begin en_x = onehot;  nr_x = onehot;  busy_x = 1'b0; act_x = a;    end
        endcase
        n_checks++;
        assert (bus.core_en === en_x) else begin
            n_fail++;
            $error("FAIL %s core_en observed=%b expected=%b", tag, bus.core_en, en_x);
        end
        n_checks++;
        assert (bus.core_nreset === nr_x) else begin
            n_fail++;
            $error("FAIL %s core_nreset observed=%b expected=%b", tag, bus.core_nreset, nr_x);
        end
        n_checks++;
        assert (bus.busy === busy_x) else begin
            n_fail++;
            $error("FAIL %s busy observed=%b expected=%b", tag, bus.busy, busy_x);
        end
        n_checks++;
        assert (bus.active_cpu === act_x) else begin
            n_fail++;
            $error("FAIL %s active_cpu observed=%0d expected=%0d", tag, bus.active_cpu, act_x);
        end
    endtask

    // n consecutive edges all showing the same phase.
    task automatic expect_n(input string tag, input int n, input kind_e k, input logic [1:0] a);
        for (int i = 0; i < n; i++) begin
            tick();
            check_out($sformatf("%s[%0d]", tag, i), k, a);
        end
    endtask

    // Full bring-up of core a once the triggering edge has been observed.
    task automatic bringup(input string tag, input logic [1:0] a);
        expect_n({tag, "_settle"}, S, K_SETTLE, a);
        expect_n({tag, "_hold"},   H, K_HOLD,   a);
        expect_n({tag, "_run"},    2, K_RUN,    a);
    endtask

    // Core switch requested while running.
    task automatic do_switch(input string tag, input logic [1:0] to);
        bus.cpu_sel = to;
        expect_n({tag, "_old"}, 1, K_RUN, cur);
        bringup(tag, to);
        cur = to;
    endtask

    // Switch to a, then to b two edges later while still settling.
    task automatic settle_switch(input string tag, input logic [1:0] a, input logic [1:0] b);
        bus.cpu_sel = a;
        expect_n({tag, "_old"}, 1, K_RUN, cur);
        expect_n({tag, "_first"}, 1, K_SETTLE, a);
        bus.cpu_sel = b;
        expect_n({tag, "_first"}, 1, K_SETTLE, a);
        bringup(tag, b);
        cur = b;
    endtask

    // sw_reset high for n edges while running.
    task automatic sw_pulse(input string tag, input int n);
        bus.sw_reset = 1'b1;
        expect_n({tag, "_old"}, 1, K_RUN, cur);
        expect_n({tag, "_held"}, n - 1, K_HOLD, cur);
        bus.sw_reset = 1'b0;
        expect_n({tag, "_tail"}, H, K_HOLD, cur);
        expect_n({tag, "_run"}, 2, K_RUN, cur);
    endtask

    // Any core other than x.
    function automatic logic [1:0] pick_other(input logic [1:0] x);
        logic [1:0] r;
        r = 2'(x + 2'($urandom_range(1, 3)));
        return r;
    endfunction

    initial begin
        logic [1:0] a;
        logic [1:0] b;

        reset              = 1'b1;
        bus.locked         = 1'b0;
        bus.sw_reset       = 1'b0;
        bus.img_mounted    = 1'b0;
        bus.mount_reset_en = 1'b0;
        bus.cpu_sel        = 2'd2;
        cur                = 2'd2;

        // Reset values, then idle without lock.
        expect_n("in_reset", 3, K_WAIT, 2'd0);
        reset = 1'b0;
        expect_n("no_lock", 6, K_WAIT, 2'd0);

        // Lock-up: two synchroniser edges plus the WAIT_LOCK exit edge.
        bus.locked = 1'b1;
        expect_n("lockup_sync", 3, K_WAIT, 2'd0);
        bringup("lockup", 2'd2);
        expect_n("run_idle", int'($urandom_range(1, 5)), K_RUN, cur);

        // Directed switch 2->1, then random switches.
        do_switch("switch_2to1", 2'd1);
        for (int i = 0; i < 3; i++) begin
            do_switch($sformatf("switch_rand%0d", i), pick_other(cur));
            expect_n("run_idle", int'($urandom_range(1, 4)), K_RUN, cur);
        end

        // Switch while settling: reach core 0, then 0->3->1, then random.
        if (cur != 2'd0) do_switch("switch_to0", 2'd0);
        settle_switch("settle_3to1", 2'd3, 2'd1);
        a = pick_other(cur);
        b = pick_other(a);
        settle_switch("settle_rand", a, b);

        // sw_reset: 5 edges, 1 edge, and a random length.
        sw_pulse("sw5", 5);
        sw_pulse("sw1", 1);
        sw_pulse("sw_rand", int'($urandom_range(2, 7)));

        // Core switch and sw_reset together: the switch wins, and sw_reset
        // seen during SETTLE is ignored.
        a = pick_other(cur);
        bus.cpu_sel  = a;
        bus.sw_reset = 1'b1;
        expect_n("prio_old", 1, K_RUN, cur);
        expect_n("prio_settle", 1, K_SETTLE, a);
        bus.sw_reset = 1'b0;
        expect_n("prio_settle", S - 1, K_SETTLE, a);
        expect_n("prio_hold", H, K_HOLD, a);
        expect_n("prio_run", 2, K_RUN, a);
        cur = a;

        // Mount strobe with mount_reset_en=1.
        bus.img_mounted    = 1'b1;
        bus.mount_reset_en = 1'b1;
        expect_n("mount_en_old", 1, K_RUN, cur);
        bus.img_mounted = 1'b0;
`ifdef CORE_RESET_SEQ_MOUNT_RESET_EN
        expect_n("mount_en_hold", H, K_HOLD, cur);
        expect_n("mount_en_run", 2, K_RUN, cur);
`else
        expect_n("mount_en_ignored", H + 2, K_RUN, cur);
`endif
        // Mount strobe with mount_reset_en=0 never has an effect.
        bus.img_mounted    = 1'b1;
        bus.mount_reset_en = 1'b0;
        expect_n("mount_dis_old", 1, K_RUN, cur);
        bus.img_mounted = 1'b0;
        expect_n("mount_dis_ignored", H + 2, K_RUN, cur);

        // Lock loss in RUN, then re-lock replays the bring-up.
        bus.locked = 1'b0;
        expect_n("lockloss_sync", 3, K_RUN, cur);
        expect_n("lockloss_wait", 4, K_WAIT, 2'd0);
        bus.locked = 1'b1;
        expect_n("relock_sync", 3, K_WAIT, 2'd0);
        bringup("relock", cur);

        // Reset mid-HOLD: outputs clear at once and the next bring-up is full
        // length, so no count survives.
        a = pick_other(cur);
        bus.cpu_sel = a;
        expect_n("rst_mid_old", 1, K_RUN, cur);
        expect_n("rst_mid_settle", S, K_SETTLE, a);
        expect_n("rst_mid_hold", 3, K_HOLD, a);
        #2;
        reset = 1'b1;
        #1;
        check_out("rst_async", K_WAIT, 2'd0);
        expect_n("rst_held", 2, K_WAIT, 2'd0);
        reset = 1'b0;
        expect_n("rst_release_sync", 3, K_WAIT, 2'd0);
        bringup("after_reset", a);
        cur = a;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
